// File: rtl/prand_lfsr.sv
// prand_lfsr - parametrised Fibonacci LFSR random-word generator.
//
// Shifts a WIDTH-bit Fibonacci LFSR (feedback = XOR of the bits selected by
// TAPS, shifted in at the LSB) and packs OUT_W freshly generated bits into
// each output word. Words leave over a valid/ready handshake with
// back-pressure. After reset or a seed load, WARMUP shifts are discarded
// before the first word is built. A zero seed is replaced by DEFAULT_SEED so
// the all-zero lock-up state can never be entered.
//
// Ports:
//   clk        in   1      clock, rising edge
//   pReset     in   1      asynchronous active-high reset
//   runRand    in   1      generator enable; 0 freezes shifting
//   seedLoad   in   1      synchronous seed load strobe (priority over all but reset)
//   seed       in   WIDTH  seed value, sampled when seedLoad=1
//   outReady   in   1      consumer ready
//   outValid   out  1      randNum holds a fresh word
//   randNum    out  OUT_W  output word, newest bit in the LSB
//   seedZero   out  1      one-cycle pulse: zero seed replaced by DEFAULT_SEED
//   lfsrState  out  WIDTH  current LFSR state (debug)
module prand_lfsr #(
  parameter int unsigned       WIDTH        = 64,
  parameter logic [WIDTH-1:0]  TAPS         = 64'hD800_0000_0000_0000,
  parameter int unsigned       OUT_W        = 8,
  parameter int unsigned       WARMUP       = 16,
  parameter logic [WIDTH-1:0]  DEFAULT_SEED = 64'h0123_4567_89AB_CDEF
) (
  input  logic             clk,
  input  logic             pReset,
  input  logic             runRand,
  input  logic             seedLoad,
  input  logic [WIDTH-1:0] seed,
  input  logic             outReady,
  output logic             outValid,
  output logic [OUT_W-1:0] randNum,
  output logic             seedZero,
  output logic [WIDTH-1:0] lfsrState
);

  // Counter widths: cnt spans 0..OUT_W, warmCnt spans 0..WARMUP.
  localparam int unsigned CW  = $clog2(OUT_W + 1);
  localparam int unsigned WCW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

  localparam logic [CW-1:0]  CNT_LAST  = CW'(OUT_W - 1);
  localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
  localparam logic [WCW-1:0] WARM_INIT = WCW'(WARMUP);
  localparam logic [WCW-1:0] WARM_ONE  = WCW'(1);

  typedef enum logic [1:0] {
    WARM = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } fsm_e;

  // With no warm-up the generator starts building a word straight away.
  localparam fsm_e START_ST = (WARMUP == 0) ? FILL : WARM;

  logic [WIDTH-1:0] lfsr_q,      lfsr_d;
  fsm_e             fsm_q,       fsm_d;
  logic [WCW-1:0]   warm_cnt_q,  warm_cnt_d;
  logic [CW-1:0]    cnt_q,       cnt_d;
  logic             valid_q,     valid_d;
  logic [OUT_W-1:0] rand_q,      rand_d;
  logic             seed_zero_q, seed_zero_d;

  logic             fb;
  logic [WIDTH-1:0] shifted;
  logic             seed_is_zero;

  assign fb           = ^(lfsr_q & TAPS);
  assign shifted      = {lfsr_q[WIDTH-2:0], fb};
  assign seed_is_zero = (seed == '0);

  always_ff @(posedge clk or posedge pReset) begin
    if (pReset) begin
      lfsr_q      <= DEFAULT_SEED;
      fsm_q       <= START_ST;
      warm_cnt_q  <= WARM_INIT;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      rand_q      <= '0;
      seed_zero_q <= 1'b0;
    end else begin
      lfsr_q      <= lfsr_d;
      fsm_q       <= fsm_d;
      warm_cnt_q  <= warm_cnt_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      rand_q      <= rand_d;
      seed_zero_q <= seed_zero_d;
    end
  end

  always_comb begin
    lfsr_d      = lfsr_q;
    fsm_d       = fsm_q;
    warm_cnt_d  = warm_cnt_q;
    cnt_d       = cnt_q;
    valid_d     = valid_q;
    rand_d      = rand_q;
    seed_zero_d = 1'b0;

    if (seedLoad) begin
      // Load wins over shifting and over any pending word, which is dropped.
      lfsr_d      = seed_is_zero ? DEFAULT_SEED : seed;
      seed_zero_d = seed_is_zero;
      valid_d     = 1'b0;
      cnt_d       = '0;
      warm_cnt_d  = WARM_INIT;
      fsm_d       = START_ST;
    end else begin
      unique case (fsm_q)
        WARM: begin
          if (runRand) begin
            lfsr_d     = shifted;
            warm_cnt_d = warm_cnt_q - WARM_ONE;
            if (warm_cnt_q == WARM_ONE) begin
              fsm_d = FILL;
              cnt_d = '0;
            end
          end
        end

        FILL: begin
          if (runRand) begin
            lfsr_d = shifted;
            cnt_d  = cnt_q + CNT_ONE;
            // This shift supplies the last bit of the word.
            if (cnt_q == CNT_LAST) begin
              rand_d  = shifted[OUT_W-1:0];
              valid_d = 1'b1;
              fsm_d   = HOLD;
            end
          end
        end

        HOLD: begin
          // Acceptance does not need runRand; only the shift does.
          if (outReady) begin
            if (runRand) begin
              lfsr_d = shifted;
              cnt_d  = CNT_ONE;
              if (OUT_W == 1) begin
                // The shift in the accept cycle already completes a 1-bit word.
                rand_d  = shifted[OUT_W-1:0];
                valid_d = 1'b1;
                fsm_d   = HOLD;
              end else begin
                valid_d = 1'b0;
                fsm_d   = FILL;
              end
            end else begin
              cnt_d   = '0;
              valid_d = 1'b0;
              fsm_d   = FILL;
            end
          end
        end

        default: begin
          fsm_d   = START_ST;
          valid_d = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign outValid  = valid_q;
  assign randNum   = rand_q;
  assign seedZero  = seed_zero_q;
  assign lfsrState = lfsr_q;

endmodule
